// File: rtl/jtag_bsc_pkg.sv
// Shared types and defaults for the parametrised boundary-scan chain.
// The control struct bundles the per-cell strobes fanned out by the chain top.
package jtag_bsc_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef struct packed {
        logic capture;
        logic shift;
        logic update;
        logic extest;
    } bsc_ctrl_t;

endpackage

// File: rtl/boundary_scan_cell.sv
// One boundary-scan cell: a capture/shift flop, an update latch and the
// EXTEST output mux selecting between the latch and the core/pad value.
module boundary_scan_cell
    import jtag_bsc_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic      tck,
    input  logic      rst,
    input  bsc_ctrl_t ctrl,
    input  logic      serial_in,
    input  logic      data_in,
    output logic      serial_out,
    output logic      data_out
);

    logic shift_q;
    logic shift_d;
    logic update_q;
    logic update_d;

    // Capture beats shift; update samples the pre-edge shift value.
    always_comb begin
        shift_d  = shift_q;
        update_d = update_q;
        if (ctrl.capture) begin
            shift_d = data_in;
        end else if (ctrl.shift) begin
            shift_d = serial_in;
        end
        if (ctrl.update) begin
            update_d = shift_q;
        end
    end

    always_ff @(posedge tck) begin
        if (rst) begin
            shift_q  <= 1'b0;
            update_q <= RESET_VAL;
        end else begin
            shift_q  <= shift_d;
            update_q <= update_d;
        end
    end

    assign serial_out = shift_q;
    assign data_out   = ctrl.extest ? update_q : data_in;

endmodule

// File: rtl/boundary_scan_chain_param.sv
// WIDTH-cell boundary-scan register with bypass path, saturating shift
// counter and chain-complete flag; cells shift from tdi toward tdo.
module boundary_scan_chain_param
    import jtag_bsc_pkg::*;
#(
    parameter int              WIDTH        = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] UPDATE_RESET = '0,
    localparam int             CNT_W        = $clog2(WIDTH + 1)
) (
    input  logic             tck,
    input  logic             rst,
    input  logic             tdi,
    output logic             tdo,
    input  logic             capture_en,
    input  logic             shift_en,
    input  logic             update_en,
    input  logic             extest,
    input  logic             bypass_en,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             chain_done
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    bsc_ctrl_t        cell_ctrl;
    logic [WIDTH-1:0] serial_in;
    logic [WIDTH-1:0] serial_out;
    logic             bypass_q;
    logic             bypass_d;
    logic [CNT_W-1:0] shift_cnt_q;
    logic [CNT_W-1:0] shift_cnt_d;

    // Bypass freezes the chain's shift stage but still lets update through.
    always_comb begin
        cell_ctrl.capture = capture_en & ~bypass_en;
        cell_ctrl.shift   = shift_en & ~bypass_en;
        cell_ctrl.update  = update_en;
        cell_ctrl.extest  = extest;
    end

    assign serial_in = {tdi, serial_out[WIDTH-1:1]};

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        boundary_scan_cell #(
            .RESET_VAL (UPDATE_RESET[i])
        ) u_cell (
            .tck        (tck),
            .rst        (rst),
            .ctrl       (cell_ctrl),
            .serial_in  (serial_in[i]),
            .data_in    (data_in[i]),
            .serial_out (serial_out[i]),
            .data_out   (data_out[i])
        );
    end

    always_comb begin
        bypass_d    = bypass_q;
        shift_cnt_d = shift_cnt_q;
        if (bypass_en) begin
            if (shift_en) begin
                bypass_d = tdi;
            end
        end else if (capture_en) begin
            shift_cnt_d = '0;
        end else if (shift_en && (shift_cnt_q != CNT_MAX)) begin
            shift_cnt_d = shift_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge tck) begin
        if (rst) begin
            bypass_q    <= 1'b0;
            shift_cnt_q <= '0;
        end else begin
            bypass_q    <= bypass_d;
            shift_cnt_q <= shift_cnt_d;
        end
    end

    assign tdo        = bypass_en ? bypass_q : serial_out[0];
    assign shift_cnt  = shift_cnt_q;
    assign chain_done = (shift_cnt_q == CNT_MAX);

endmodule
